// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchy fan-out node.
//   dispatch_state_e : dispatch FSM states
//   MAX_CHILD        : largest supported child count
//   clog2_min1       : $clog2 with a floor of 1, for index/counter widths
package hier_node_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } dispatch_state_e;

   localparam int MAX_CHILD = 64;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hier_fanout_dispatch_if.sv
// Bus bundle between one upstream port and NUM_CHILD child ports.
// Every channel uses valid/ready: a transfer happens in the cycle where both
// valid and ready are high; once valid is raised, its payload stays stable
// until that transfer, and valid never drops before it.
//   req_*     : upstream request into the node
//   chd_req_* : node requests to children (valid one-hot, shared data)
//   chd_rsp_* : child responses into the node (ready one-hot)
//   rsp_*     : merged upstream response, rsp_id names the source child
// Modports: slave = the node, master = its environment.
interface hier_fanout_dispatch_if import hier_node_pkg::*; #(
   parameter  int NUM_CHILD = 15,
   parameter  int DATA_W    = 32,
   localparam int IDX_W     = clog2_min1(NUM_CHILD)
);
   logic                        req_valid;
   logic                        req_ready;
   logic [DATA_W-1:0]           req_data;
   logic [NUM_CHILD-1:0]        chd_req_valid;
   logic [NUM_CHILD-1:0]        chd_req_ready;
   logic [DATA_W-1:0]           chd_req_data;
   logic [NUM_CHILD-1:0]        chd_rsp_valid;
   logic [NUM_CHILD-1:0]        chd_rsp_ready;
   logic [NUM_CHILD*DATA_W-1:0] chd_rsp_data;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [DATA_W-1:0]           rsp_data;
   logic [IDX_W-1:0]            rsp_id;

   modport slave (
      input  req_valid, req_data, chd_req_ready, chd_rsp_valid, chd_rsp_data, rsp_ready,
      output req_ready, chd_req_valid, chd_req_data, chd_rsp_ready, rsp_valid, rsp_data, rsp_id
   );

   modport master (
      output req_valid, req_data, chd_req_ready, chd_rsp_valid, chd_rsp_data, rsp_ready,
      input  req_ready, chd_req_valid, chd_req_data, chd_rsp_ready, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : highest-priority index this cycle (must be < N)
//   gnt     : one-hot grant, zero when no request
//   gnt_idx : index of the granted request (0 when none)
module rr_arbiter import hier_node_pkg::*; #(
   parameter  int N     = 4,
   localparam int IDX_W = clog2_min1(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   always_comb begin
      logic [IDX_W-1:0] idx;
      logic             found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      // Walk N positions starting at ptr; the first requester wins.
      for (int i = 0; i < N; i++) begin
         idx = IDX_W'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            gnt[idx]   = 1'b1;
            gnt_idx    = idx;
         end
      end
   end

endmodule

// File: rtl/hier_fanout_dispatch.sv
// Hierarchy node: fans one upstream request stream out to NUM_CHILD children
// with round-robin, credit-gated dispatch, and merges child responses back
// through a round-robin arbiter tagged with the child index.
// Optional feature macro: CHILD_MASK_EN (adds child_mask input; 0 = child
// not eligible for dispatch, responses still accepted).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : request/response bundle (slave modport)
//   child_mask  : per-child dispatch enable (CHILD_MASK_EN only)
//   drain       : level, stop accepting new requests
//   drain_done  : draining and no request outstanding at any child
//   busy        : request held, response held, or any child outstanding
//   state_dbg   : dispatch FSM state
//   outst_dbg   : per-child outstanding counts, child i at [i*CNT_W +: CNT_W]
module hier_fanout_dispatch import hier_node_pkg::*; #(
   parameter  int NUM_CHILD = 15,
   parameter  int DATA_W    = 32,
   parameter  int MAX_OUTST = 4,
   localparam int IDX_W     = clog2_min1(NUM_CHILD),
   localparam int CNT_W     = clog2_min1(MAX_OUTST + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   hier_fanout_dispatch_if.slave      bus,
`ifdef CHILD_MASK_EN
   input  logic [NUM_CHILD-1:0]       child_mask,
`endif
   input  logic                       drain,
   output logic                       drain_done,
   output logic                       busy,
   output dispatch_state_e            state_dbg,
   output logic [NUM_CHILD*CNT_W-1:0] outst_dbg
);

   dispatch_state_e      state, state_nxt;
   logic [IDX_W-1:0]     req_ptr, target, rsp_ptr, d_idx, r_idx;
   logic [DATA_W-1:0]    hold_data;
   logic [CNT_W-1:0]     outst [NUM_CHILD];
   logic [NUM_CHILD-1:0] eligible, d_gnt, r_gnt, inc, dec;
   logic                 accept, chd_hs, rsp_load, any_outst;

   always_comb begin
      eligible  = '0;
      any_outst = 1'b0;
      outst_dbg = '0;
      for (int c = 0; c < NUM_CHILD; c++) begin
`ifdef CHILD_MASK_EN
         eligible[c] = (outst[c] < CNT_W'(MAX_OUTST)) && child_mask[c];
`else
         eligible[c] = (outst[c] < CNT_W'(MAX_OUTST));
`endif
         any_outst = any_outst | (outst[c] != '0);
         outst_dbg[c*CNT_W +: CNT_W] = outst[c];
      end
   end

   rr_arbiter #(.N(NUM_CHILD)) u_disp_arb (
      .req(eligible), .ptr(req_ptr), .gnt(d_gnt), .gnt_idx(d_idx)
   );

   // Dispatch FSM, next state and outputs.
   always_comb begin
      state_nxt         = state;
      bus.req_ready     = 1'b0;
      bus.chd_req_valid = '0;
      drain_done        = 1'b0;
      accept            = 1'b0;
      chd_hs            = 1'b0;
      case (state)
         IDLE: begin
            if (drain) begin
               state_nxt = DRAIN;
            end else begin
               bus.req_ready = |d_gnt;
               accept        = bus.req_valid && (|d_gnt);
               if (accept) state_nxt = HOLD;
            end
         end
         HOLD: begin
            // drain is ignored here; IDLE picks it up after the handshake.
            bus.chd_req_valid[target] = 1'b1;
            chd_hs = bus.chd_req_ready[target];
            if (chd_hs) state_nxt = IDLE;
         end
         DRAIN: begin
            drain_done = !any_outst;
            if (!drain) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ptr   <= '0;
         target    <= '0;
         hold_data <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            hold_data <= bus.req_data;
            target    <= d_idx;
         end
         if (chd_hs) req_ptr <= (target == IDX_W'(NUM_CHILD - 1)) ? '0 : target + 1'b1;
      end
   end

   assign bus.chd_req_data = hold_data;

   // Outstanding credits: simultaneous issue and return cancel out.
   assign inc = bus.chd_req_valid & bus.chd_req_ready;
   assign dec = bus.chd_rsp_valid & bus.chd_rsp_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CHILD; c++) outst[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_CHILD; c++) begin
            if (inc[c] && !dec[c])      outst[c] <= outst[c] + 1'b1;
            else if (!inc[c] && dec[c]) outst[c] <= outst[c] - 1'b1;
         end
      end
   end

   rr_arbiter #(.N(NUM_CHILD)) u_rsp_arb (
      .req(bus.chd_rsp_valid), .ptr(rsp_ptr), .gnt(r_gnt), .gnt_idx(r_idx)
   );

   // Output register refills whenever it is empty or being drained this cycle.
   assign rsp_load          = (!bus.rsp_valid || bus.rsp_ready) && (|r_gnt);
   assign bus.chd_rsp_ready = rsp_load ? r_gnt : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_id    <= '0;
         rsp_ptr       <= '0;
      end else if (rsp_load) begin
         bus.rsp_valid <= 1'b1;
         bus.rsp_data  <= bus.chd_rsp_data[int'(r_idx)*DATA_W +: DATA_W];
         bus.rsp_id    <= r_idx;
         rsp_ptr       <= (r_idx == IDX_W'(NUM_CHILD - 1)) ? '0 : r_idx + 1'b1;
      end else if (bus.rsp_ready) begin
         bus.rsp_valid <= 1'b0;
      end
   end

   assign busy      = (state == HOLD) | bus.rsp_valid | any_outst;
   assign state_dbg = state;

endmodule

// File: tb/tb_hier_fanout_dispatch.sv
module tb_hier_fanout_dispatch;
   import hier_node_pkg::*;

   localparam int NC = 15;
   localparam int DW = 32;
   localparam int MO = 4;
   localparam int CW = 3;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            drain = 1'b0;
   logic            drain_done, busy;
   dispatch_state_e state_dbg;
   logic [NC*CW-1:0] outst_dbg;
`ifdef CHILD_MASK_EN
   logic [NC-1:0]   child_mask = '1;
`endif

   int total = 0;
   int bad   = 0;

   hier_fanout_dispatch_if #(.NUM_CHILD(NC), .DATA_W(DW)) bus ();

   hier_fanout_dispatch #(.NUM_CHILD(NC), .DATA_W(DW), .MAX_OUTST(MO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
`ifdef CHILD_MASK_EN
      .child_mask (child_mask),
`endif
      .drain      (drain),
      .drain_done (drain_done),
      .busy       (busy),
      .state_dbg  (state_dbg),
      .outst_dbg  (outst_dbg)
   );

   // clock
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [NC-1:0] oh(input int i);
      return NC'(1) << i;
   endfunction

   function automatic logic [CW-1:0] cnt(input int c);
      return outst_dbg[c*CW +: CW];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reset with quiet inputs; returns at a falling edge with rst_n released.
   task automatic do_reset();
      rst_n             = 1'b0;
      drain             = 1'b0;
      bus.req_valid     = 1'b0;
      bus.req_data      = '0;
      bus.chd_req_ready = '1;
      bus.chd_rsp_valid = '0;
      bus.chd_rsp_data  = '0;
      bus.rsp_ready     = 1'b1;
`ifdef CHILD_MASK_EN
      child_mask        = '1;
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_state"},     64'(state_dbg),         64'(IDLE));
      check({tag, "_chd_req_v"}, 64'(bus.chd_req_valid), 64'(0));
      check({tag, "_chd_rsp_r"}, 64'(bus.chd_rsp_ready), 64'(0));
      check({tag, "_rsp_valid"}, 64'(bus.rsp_valid),     64'(0));
      check({tag, "_rsp_data"},  64'(bus.rsp_data),      64'(0));
      check({tag, "_rsp_id"},    64'(bus.rsp_id),        64'(0));
      check({tag, "_chd_data"},  64'(bus.chd_req_data),  64'(0));
      check({tag, "_drain_done"},64'(drain_done),        64'(0));
      check({tag, "_busy"},      64'(busy),              64'(0));
      check({tag, "_outst"},     64'(outst_dbg),         64'(0));
   endtask

   // One request from IDLE: accepted on the next edge, offered to child tgt
   // for one cycle, handshake completes on the edge after. req_valid stays 1.
   task automatic dispatch(input logic [DW-1:0] d, input int tgt);
      bus.req_valid = 1'b1;
      bus.req_data  = d;
      #1;
      check("req_ready_idle", 64'(bus.req_ready), 64'(1));
      @(negedge clk);
      check("chd_req_valid", 64'(bus.chd_req_valid), 64'(oh(tgt)));
      check("chd_req_data",  64'(bus.chd_req_data),  64'(d));
      check("req_ready_hold", 64'(bus.req_ready),    64'(0));
      @(negedge clk);
   endtask

   // Single child response with rsp_ready high; returns with it loaded.
   task automatic rsp_one(input int c, input logic [DW-1:0] d);
      bus.chd_rsp_data[c*DW +: DW] = d;
      bus.chd_rsp_valid = oh(c);
      #1;
      check("chd_rsp_ready", 64'(bus.chd_rsp_ready), 64'(oh(c)));
      @(negedge clk);
      bus.chd_rsp_valid = '0;
      check("rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("rsp_id",    64'(bus.rsp_id),    64'(c));
      check("rsp_data",  64'(bus.rsp_data),  64'(d));
   endtask

   initial begin
      logic [NC*CW-1:0] exp_cnt;

      // 1: 30 back-to-back requests, round-robin 0..14 twice
      do_reset();
      check_reset_vals("rst1");
      for (int k = 0; k < 30; k++) dispatch(32'h100 + k, k % 15);
      bus.req_valid = 1'b0;
      exp_cnt = '0;
      for (int c = 0; c < NC; c++) exp_cnt[c*CW +: CW] = CW'(2);
      check("cnt_after_30", 64'(outst_dbg), 64'(exp_cnt));

      // 2: credit exhaustion after 60, freed credit on child 3
      do_reset();
      for (int k = 0; k < 60; k++) dispatch(32'h200 + k, k % 15);
      bus.req_data = 32'h2FF;
      #1;
      check("full_req_ready", 64'(bus.req_ready), 64'(0));
      repeat (2) @(negedge clk);
      check("full_no_valid", 64'(bus.chd_req_valid), 64'(0));
      check("full_state",    64'(state_dbg),         64'(IDLE));
      check("full_busy",     64'(busy),              64'(1));
      rsp_one(3, 32'hC3);
      check("cnt3_freed",    64'(cnt(3)),        64'(3));
      check("req_ready_c3",  64'(bus.req_ready), 64'(1));
      @(negedge clk);
      check("tgt_c3",      64'(bus.chd_req_valid), 64'(oh(3)));
      check("tgt_c3_data", 64'(bus.chd_req_data),  64'(32'h2FF));
      check("rsp_cleared", 64'(bus.rsp_valid),     64'(0));
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("cnt3_full", 64'(cnt(3)), 64'(4));

      // 3: simultaneous responses from 2, 5, 9
      do_reset();
      for (int k = 0; k < 15; k++) dispatch(32'h300 + k, k);
      bus.req_valid = 1'b0;
      bus.chd_rsp_data[2*DW +: DW] = 32'hA2;
      bus.chd_rsp_data[5*DW +: DW] = 32'hA5;
      bus.chd_rsp_data[9*DW +: DW] = 32'hA9;
      bus.chd_rsp_valid = oh(2) | oh(5) | oh(9);
      #1;
      check("m_gnt2", 64'(bus.chd_rsp_ready), 64'(oh(2)));
      @(negedge clk);
      bus.chd_rsp_valid = oh(5) | oh(9);
      #1;
      check("m_id2",   64'(bus.rsp_id),        64'(2));
      check("m_dat2",  64'(bus.rsp_data),      64'(32'hA2));
      check("m_gnt5",  64'(bus.chd_rsp_ready), 64'(oh(5)));
      @(negedge clk);
      bus.chd_rsp_valid = oh(9);
      #1;
      check("m_id5",   64'(bus.rsp_id),        64'(5));
      check("m_dat5",  64'(bus.rsp_data),      64'(32'hA5));
      check("m_gnt9",  64'(bus.chd_rsp_ready), 64'(oh(9)));
      @(negedge clk);
      bus.chd_rsp_valid = '0;
      check("m_id9",   64'(bus.rsp_id),    64'(9));
      check("m_dat9",  64'(bus.rsp_data),  64'(32'hA9));
      check("m_v9",    64'(bus.rsp_valid), 64'(1));
      check("m_cnt2",  64'(cnt(2)), 64'(0));
      check("m_cnt5",  64'(cnt(5)), 64'(0));
      check("m_cnt9",  64'(cnt(9)), 64'(0));
      check("m_cnt0",  64'(cnt(0)), 64'(1));
      @(negedge clk);
      check("m_empty", 64'(bus.rsp_valid), 64'(0));

      // 4: same-cycle issue and return on child 7 at count 2
      do_reset();
      for (int k = 0; k < 37; k++) dispatch(32'h400 + k, k % 15);
      bus.req_valid = 1'b0;
      check("c7_pre", 64'(cnt(7)), 64'(2));
      bus.chd_req_ready = '0;
      bus.req_valid     = 1'b1;
      bus.req_data      = 32'h4FF;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("c7_hold", 64'(bus.chd_req_valid), 64'(oh(7)));
      bus.chd_req_ready = '1;
      bus.chd_rsp_data[7*DW +: DW] = 32'hB7;
      bus.chd_rsp_valid = oh(7);
      #1;
      check("c7_rsp_gnt", 64'(bus.chd_rsp_ready), 64'(oh(7)));
      @(negedge clk);
      bus.chd_rsp_valid = '0;
      check("c7_cnt",   64'(cnt(7)),     64'(2));
      check("c7_id",    64'(bus.rsp_id), 64'(7));
      check("c7_state", 64'(state_dbg),  64'(IDLE));

      // 5: stalled HOLD, drain arriving in HOLD, drain completion
      do_reset();
      dispatch(32'h501, 0);
      dispatch(32'h502, 1);
      bus.chd_req_ready = '0;
      bus.req_data      = 32'h503;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("st_state", 64'(state_dbg),         64'(HOLD));
      check("st_valid", 64'(bus.chd_req_valid), 64'(oh(2)));
      drain = 1'b1;
      @(negedge clk);
      check("st2_state", 64'(state_dbg),         64'(HOLD));
      check("st2_valid", 64'(bus.chd_req_valid), 64'(oh(2)));
      check("st2_data",  64'(bus.chd_req_data),  64'(32'h503));
      bus.chd_req_ready = '1;
      @(negedge clk);
      check("dr_idle",      64'(state_dbg),     64'(IDLE));
      check("dr_req_ready", 64'(bus.req_ready), 64'(0));
      check("dr_cnt2",      64'(cnt(2)),        64'(1));
      @(negedge clk);
      check("dr_state", 64'(state_dbg),  64'(DRAIN));
      check("dr_done0", 64'(drain_done), 64'(0));
      bus.rsp_ready = 1'b0;
      rsp_one(0, 32'hD0);
      check("dr_done1", 64'(drain_done), 64'(0));
      bus.chd_rsp_data[1*DW +: DW] = 32'hD1;
      bus.chd_rsp_valid = oh(1);
      #1;
      check("blk_gnt", 64'(bus.chd_rsp_ready), 64'(0));
      @(negedge clk);
      check("blk_id",   64'(bus.rsp_id),   64'(0));
      check("blk_data", 64'(bus.rsp_data), 64'(32'hD0));
      bus.rsp_ready = 1'b1;
      #1;
      check("unblk_gnt", 64'(bus.chd_rsp_ready), 64'(oh(1)));
      @(negedge clk);
      bus.chd_rsp_valid = '0;
      check("dr_id1",   64'(bus.rsp_id), 64'(1));
      check("dr_done2", 64'(drain_done), 64'(0));
      rsp_one(2, 32'hD2);
      check("dr_done3",  64'(drain_done),    64'(1));
      check("dr_rdy3",   64'(bus.req_ready), 64'(0));
      drain = 1'b0;
      @(negedge clk);
      check("undrain_state", 64'(state_dbg),     64'(IDLE));
      check("undrain_rdy",   64'(bus.req_ready), 64'(1));
      check("undrain_busy",  64'(busy),          64'(0));

      // 6: reset while HOLD with a response held
      do_reset();
      dispatch(32'h600, 0);
      dispatch(32'h601, 1);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      rsp_one(0, 32'hE0);
      bus.chd_req_ready = '0;
      bus.req_valid     = 1'b1;
      bus.req_data      = 32'h602;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("pre_state", 64'(state_dbg),     64'(HOLD));
      check("pre_rspv",  64'(bus.rsp_valid), 64'(1));
      check("pre_cnt1",  64'(cnt(1)),        64'(1));
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("rst6");
      rst_n = 1'b1;
      bus.chd_req_ready = '1;
      bus.rsp_ready     = 1'b1;

`ifdef CHILD_MASK_EN
      // 7: masked child 0 never targeted; all-zero mask blocks requests
      do_reset();
      child_mask = 15'h7FFE;
      for (int k = 0; k < 16; k++) dispatch(32'h700 + k, 1 + (k % 14));
      bus.req_valid = 1'b0;
      check("mask_cnt0", 64'(cnt(0)), 64'(0));
      child_mask    = '0;
      bus.req_valid = 1'b1;
      #1;
      check("mask0_rdy", 64'(bus.req_ready), 64'(0));
      @(negedge clk);
      check("mask0_state", 64'(state_dbg), 64'(IDLE));
      bus.req_valid = 1'b0;
      child_mask    = '1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
